// File: rtl/aes_sched_pkg.sv
// Shared types for the AES job scheduler: FSM states, engine commands, block geometry.
// Purely declarative; no latency or backpressure of its own.
package aes_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_PT,
      LOAD_KEY,
      START,
      COLLECT,
      RESP
   } state_t;

   localparam logic [1:0] CMD_ID = 2'b00;
   localparam logic [1:0] CMD_SP = 2'b01;
   localparam logic [1:0] CMD_SK = 2'b10;
   localparam logic [1:0] CMD_ST = 2'b11;

   localparam int BYTES_PER_BLOCK = 16;

   // Byte k of a block, k=0 being the most significant byte [127:120].
   function automatic logic [7:0] blk_byte(input logic [127:0] blk, input logic [3:0] k);
      logic [127:0] sh;
      sh = blk << {k, 3'b000};
      return sh[127:120];
   endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Round-robin pick of the first request at or after ptr (wrapping); purely combinational.
// No state and no backpressure: the caller decides when a grant is taken.
module aes_rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = 3
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic            gnt_any,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_idx
);

   localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IDW:0] sum;

   always_comb begin
      gnt_any = 1'b0;
      gnt     = '0;
      gnt_idx = '0;
      sum     = '0;
      for (int i = 0; i < NREQ; i++) begin
         sum = {1'b0, ptr} + (IDW+1)'(i);
         if (sum >= (IDW+1)'(NREQ)) begin
            sum = sum - (IDW+1)'(NREQ);
         end
         if (!gnt_any && req[sum[SW-1:0]]) begin
            gnt_any              = 1'b1;
            gnt[sum[SW-1:0]]     = 1'b1;
            gnt_idx              = sum[IDW-1:0];
         end
      end
   end

endmodule

// File: rtl/aes_job_scheduler.sv
// Time-shares one byte-serial AES engine among NREQ requesters; grant->first byte 1 cycle, last ct byte->res_valid 1 cycle.
// Holds the result until res_ready; no new grant while a result is pending or eng_ready is low.
module aes_job_scheduler #(
   parameter int NREQ    = 2,
   parameter int IDW     = 3,
   parameter int TIMEOUT = 256
) (
   input  logic                 clk,
   input  logic                 rst_,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*128-1:0]  req_pt,
   input  logic [NREQ*128-1:0]  req_key,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [IDW-1:0]       res_id,
   output logic [127:0]         res_ct,
   output logic                 res_err,
   output logic [1:0]           eng_cmd,
   output logic [7:0]           eng_din,
   input  logic                 eng_ready,
   input  logic [7:0]           eng_dout,
   input  logic                 eng_dok
);

   import aes_sched_pkg::*;

   localparam int         WDW       = $clog2(TIMEOUT + 1);
   localparam logic [3:0] LAST_BYTE = 4'(BYTES_PER_BLOCK - 1);

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [WDW-1:0]  wd_q, wd_d;
   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [127:0]    pt_q, pt_d;
   logic [127:0]    key_q, key_d;
   logic [127:0]    ct_q, ct_d;

   logic [NREQ-1:0] req_ready_d;
   logic            res_valid_d;
   logic [IDW-1:0]  res_id_d;
   logic [127:0]    res_ct_d;
   logic            res_err_d;
   logic [1:0]      eng_cmd_d;
   logic [7:0]      eng_din_d;

   logic            gnt_any;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_idx;

   aes_rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr_q),
      .gnt_any (gnt_any),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // Engine bus outputs are computed from the current state and appear one cycle later,
   // so the byte stream trails the state by exactly one cycle with no gaps.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wd_d        = wd_q;
      rr_ptr_d    = rr_ptr_q;
      id_d        = id_q;
      pt_d        = pt_q;
      key_d       = key_q;
      ct_d        = ct_q;
      req_ready_d = '0;
      res_valid_d = res_valid;
      res_id_d    = res_id;
      res_ct_d    = res_ct;
      res_err_d   = res_err;
      eng_cmd_d   = CMD_ID;
      eng_din_d   = '0;

      unique case (state_q)
         IDLE: begin
            if (eng_ready && gnt_any) begin
               req_ready_d = gnt;
               id_d        = gnt_idx;
               for (int i = 0; i < NREQ; i++) begin
                  if (gnt[i]) begin
                     pt_d  = req_pt[128*i +: 128];
                     key_d = req_key[128*i +: 128];
                  end
               end
               ct_d     = '0;
               cnt_d    = '0;
               wd_d     = '0;
               rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
               state_d  = LOAD_PT;
            end
         end

         LOAD_PT: begin
            eng_cmd_d = CMD_SP;
            eng_din_d = blk_byte(pt_q, cnt_q);
            cnt_d     = cnt_q + 4'd1;
            if (cnt_q == LAST_BYTE) begin
               state_d = LOAD_KEY;
            end
         end

         LOAD_KEY: begin
            eng_cmd_d = CMD_SK;
            eng_din_d = blk_byte(key_q, cnt_q);
            cnt_d     = cnt_q + 4'd1;
            if (cnt_q == LAST_BYTE) begin
               wd_d    = '0;
               state_d = START;
            end
         end

         START: begin
            if (eng_dok) begin
               ct_d    = {ct_q[119:0], eng_dout};
               cnt_d   = 4'd1;
               state_d = COLLECT;
            end else if (wd_q == WDW'(TIMEOUT - 1)) begin
               res_valid_d = 1'b1;
               res_id_d    = id_q;
               res_ct_d    = '0;
               res_err_d   = 1'b1;
               wd_d        = '0;
               state_d     = RESP;
            end else begin
               eng_cmd_d = CMD_ST;
               wd_d      = wd_q + WDW'(1);
            end
         end

         COLLECT: begin
            if (eng_dok) begin
               ct_d  = {ct_q[119:0], eng_dout};
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == LAST_BYTE) begin
                  res_valid_d = 1'b1;
                  res_id_d    = id_q;
                  res_ct_d    = {ct_q[119:0], eng_dout};
                  res_err_d   = 1'b0;
                  state_d     = RESP;
               end
            end else begin
               // Burst ended early: report an aborted job rather than a partial block.
               res_valid_d = 1'b1;
               res_id_d    = id_q;
               res_ct_d    = '0;
               res_err_d   = 1'b1;
               cnt_d       = '0;
               state_d     = RESP;
            end
         end

         RESP: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         wd_q      <= '0;
         rr_ptr_q  <= '0;
         id_q      <= '0;
         pt_q      <= '0;
         key_q     <= '0;
         ct_q      <= '0;
         req_ready <= '0;
         res_valid <= 1'b0;
         res_id    <= '0;
         res_ct    <= '0;
         res_err   <= 1'b0;
         eng_cmd   <= CMD_ID;
         eng_din   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wd_q      <= wd_d;
         rr_ptr_q  <= rr_ptr_d;
         id_q      <= id_d;
         pt_q      <= pt_d;
         key_q     <= key_d;
         ct_q      <= ct_d;
         req_ready <= req_ready_d;
         res_valid <= res_valid_d;
         res_id    <= res_id_d;
         res_ct    <= res_ct_d;
         res_err   <= res_err_d;
         eng_cmd   <= eng_cmd_d;
         eng_din   <= eng_din_d;
      end
   end

endmodule
